// File: rtl/iq_tune_pkg.sv
// iq_tune_pkg: scheduler state encoding and datapath width helpers
//   state_t  - IDLE, RETUNE, SETTLE, MEASURE, EVAL, LOCKED
//   metric_w - width of the |I|+|Q| energy metric
//   acc_w    - width of the per-channel energy accumulator
package iq_tune_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_RETUNE,
        S_SETTLE,
        S_MEASURE,
        S_EVAL,
        S_LOCKED
    } state_t;
    // One bit over the sample width so that |-2^(W-1)| + |-2^(W-1)| is exact
    function automatic int metric_w(input int iq_w);
        return iq_w + 1;
    endfunction
    // Room for 2^meas_log2 full-scale metrics, so the sum can never wrap
    function automatic int acc_w(input int iq_w, input int meas_log2);
        return metric_w(iq_w) + meas_log2;
    endfunction
endpackage

// File: rtl/iq_power_acc.sv
// iq_power_acc: accumulates |I|+|Q| over 2^MEAS_LOG2 qualified samples
//   clk, rst_n   - clock, asynchronous active-low reset
//   clear        - synchronous clear of sum and sample count (wins over en)
//   en           - add the current sample
//   i_smp, q_smp - signed I/Q sample
//   acc          - running energy sum
//   full         - 2^MEAS_LOG2 samples taken; further en is ignored
module iq_power_acc
    import iq_tune_pkg::*;
#(
    parameter int IQ_WIDTH  = 12,
    parameter int MEAS_LOG2 = 6
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  clear,
    input  logic                                  en,
    input  logic signed [IQ_WIDTH-1:0]            i_smp,
    input  logic signed [IQ_WIDTH-1:0]            q_smp,
    output logic [acc_w(IQ_WIDTH, MEAS_LOG2)-1:0] acc,
    output logic                                  full
);
    localparam int MW = metric_w(IQ_WIDTH);
    localparam int AW = acc_w(IQ_WIDTH, MEAS_LOG2);
    logic [IQ_WIDTH-1:0] abs_i;
    logic [IQ_WIDTH-1:0] abs_q;
    logic [MW-1:0]       metric;
    logic [MEAS_LOG2:0]  n;
    // Negating the most negative sample yields 2^(W-1), which is correct read as unsigned
    always_comb begin
        abs_i  = i_smp[IQ_WIDTH-1] ? -i_smp : i_smp;
        abs_q  = q_smp[IQ_WIDTH-1] ? -q_smp : q_smp;
        metric = {1'b0, abs_i} + {1'b0, abs_q};
        full   = n[MEAS_LOG2];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            n   <= '0;
        end else if (clear) begin
            acc <= '0;
            n   <= '0;
        end else if (en && !full) begin
            acc <= acc + AW'(metric);
            n   <= n + 1'b1;
        end
    end
endmodule

// File: rtl/iq_tune_scheduler.sv
// iq_tune_scheduler: LO tuning / channel-scan sequencer for the IQ demodulator
//   clk_in, RST_N          - clock, asynchronous active-low reset
//   tune_req, tune_fre     - single-channel tune request and target LO word
//   scan_start, scan_base,
//   scan_step, scan_count  - scan request: first LO, increment, channel count
//   abort                  - drop to IDLE next cycle
//   iq_valid, I_IN, Q_IN   - decimated demodulator samples
//   LO_fre, demod_rst      - demodulator LO word and its active-high reset
//   busy, locked, done     - status; done pulses once when a scan finishes
//   best_fre, best_pwr     - strongest scanned channel and its energy
module iq_tune_scheduler
    import iq_tune_pkg::*;
#(
    parameter int          IQ_WIDTH       = 12,
    parameter int          CH_WIDTH       = 8,
    parameter int          RST_CYCLES     = 16,
    parameter int          SETTLE_SAMPLES = 8,
    parameter int          MEAS_LOG2      = 6,
    parameter logic [31:0] DEFAULT_FRE    = 32'd0
) (
    input  logic                                  clk_in,
    input  logic                                  RST_N,
    input  logic                                  tune_req,
    input  logic [31:0]                           tune_fre,
    input  logic                                  scan_start,
    input  logic [31:0]                           scan_base,
    input  logic [31:0]                           scan_step,
    input  logic [CH_WIDTH-1:0]                   scan_count,
    input  logic                                  abort,
    input  logic                                  iq_valid,
    input  logic signed [IQ_WIDTH-1:0]            I_IN,
    input  logic signed [IQ_WIDTH-1:0]            Q_IN,
    output logic [31:0]                           LO_fre,
    output logic                                  demod_rst,
    output logic                                  busy,
    output logic                                  locked,
    output logic                                  done,
    output logic [31:0]                           best_fre,
    output logic [acc_w(IQ_WIDTH, MEAS_LOG2)-1:0] best_pwr
);
    localparam int AW   = acc_w(IQ_WIDTH, MEAS_LOG2);
    localparam int CMAX = RST_CYCLES > SETTLE_SAMPLES ? RST_CYCLES : SETTLE_SAMPLES;
    localparam int CW   = $clog2(CMAX + 1);
    state_t              state, state_nx;
    logic [CW-1:0]       cnt, cnt_nx;
    logic [CH_WIDTH-1:0] chan_left, chan_nx;
    logic [31:0]         step, step_nx;
    logic [31:0]         lo_nx, bfre_nx;
    logic [AW-1:0]       bpwr_nx, acc;
    logic                done_nx, demod_nx, busy_nx, locked_nx, acc_full;
    // Sum stays cleared outside MEASURE, so every channel starts from zero
    iq_power_acc #(
        .IQ_WIDTH (IQ_WIDTH),
        .MEAS_LOG2(MEAS_LOG2)
    ) u_acc (
        .clk  (clk_in),
        .rst_n(RST_N),
        .clear(state != S_MEASURE),
        .en   (state == S_MEASURE && iq_valid),
        .i_smp(I_IN),
        .q_smp(Q_IN),
        .acc  (acc),
        .full (acc_full)
    );
    // State and every output are flops; outputs are decoded from the next state
    always_ff @(posedge clk_in or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_RETUNE;
            cnt       <= '0;
            chan_left <= '0;
            step      <= '0;
            LO_fre    <= DEFAULT_FRE;
            best_fre  <= '0;
            best_pwr  <= '0;
            demod_rst <= 1'b1;
            busy      <= 1'b1;
            locked    <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            chan_left <= chan_nx;
            step      <= step_nx;
            LO_fre    <= lo_nx;
            best_fre  <= bfre_nx;
            best_pwr  <= bpwr_nx;
            demod_rst <= demod_nx;
            busy      <= busy_nx;
            locked    <= locked_nx;
            done      <= done_nx;
        end
    end
    // chan_left doubles as the scan flag: nonzero means a scan is in progress
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        chan_nx  = chan_left;
        step_nx  = step;
        lo_nx    = LO_fre;
        bfre_nx  = best_fre;
        bpwr_nx  = best_pwr;
        done_nx  = 1'b0;
        if (abort) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
            chan_nx  = '0;
        end else begin
            case (state)
                S_IDLE, S_LOCKED: begin
                    if (tune_req) begin
                        state_nx = S_RETUNE;
                        lo_nx    = tune_fre;
                        chan_nx  = '0;
                    end else if (scan_start && scan_count != '0) begin
                        state_nx = S_RETUNE;
                        lo_nx    = scan_base;
                        chan_nx  = scan_count;
                        step_nx  = scan_step;
                        bfre_nx  = '0;
                        bpwr_nx  = '0;
                    end
                end
                S_RETUNE: begin
                    if (cnt == CW'(RST_CYCLES - 1)) begin
                        state_nx = S_SETTLE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (iq_valid && cnt == CW'(SETTLE_SAMPLES - 1)) begin
                        state_nx = chan_left != '0 ? S_MEASURE : S_LOCKED;
                        cnt_nx   = '0;
                    end else if (iq_valid) begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                S_MEASURE: state_nx = acc_full ? S_EVAL : S_MEASURE;
                S_EVAL: begin
                    state_nx = S_RETUNE;
                    // Strict compare keeps the earliest channel on a tie
                    if (acc > best_pwr) begin
                        bpwr_nx = acc;
                        bfre_nx = LO_fre;
                    end
                    if (chan_left > CH_WIDTH'(1)) begin
                        chan_nx = chan_left - 1'b1;
                        lo_nx   = LO_fre + step;
                    end else begin
                        chan_nx = '0;
                        lo_nx   = bfre_nx;
                        done_nx = 1'b1;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end
    always_comb begin
        demod_nx  = state_nx == S_RETUNE;
        busy_nx   = state_nx inside {S_RETUNE, S_SETTLE, S_MEASURE, S_EVAL};
        locked_nx = state_nx == S_LOCKED;
    end
endmodule

// File: tb/tb_iq_tune_scheduler.sv
// tb_iq_tune_scheduler: random and directed checks of iq_tune_scheduler against a behavioural model
module tb_iq_tune_scheduler;
    localparam int          RST_CYCLES     = 4;
    localparam int          SETTLE_SAMPLES = 2;
    localparam int          MEAS_LOG2      = 2;
    localparam logic [31:0] DEF_FRE        = 32'h0010_0000;
    localparam int P_IDLE = 0, P_RETUNE = 1, P_SETTLE = 2, P_MEASURE = 3, P_EVAL = 4, P_LOCKED = 5;

    logic               clk_in = 1'b0;
    logic               RST_N;
    logic               tune_req, scan_start, abort, iq_valid;
    logic [31:0]        tune_fre, scan_base, scan_step;
    logic [7:0]         scan_count;
    logic signed [11:0] I_IN, Q_IN;
    logic [31:0]        LO_fre, best_fre;
    logic [14:0]        best_pwr;
    logic               demod_rst, busy, locked, done;

    int total = 0;
    int bad   = 0;
    int dones = 0;
    int iq_mode = 0;

    // Model: a phase plus "how much is left" counters, a queue of channel LO words still to visit
    int          ph, rl, sl, ml, energy, m_bp;
    logic [31:0] m_lo, m_bf;
    bit          m_scan, m_done;
    logic [31:0] chans[$];

    iq_tune_scheduler #(
        .IQ_WIDTH      (12),
        .CH_WIDTH      (8),
        .RST_CYCLES    (RST_CYCLES),
        .SETTLE_SAMPLES(SETTLE_SAMPLES),
        .MEAS_LOG2     (MEAS_LOG2),
        .DEFAULT_FRE   (DEF_FRE)
    ) dut (
        .clk_in    (clk_in),
        .RST_N     (RST_N),
        .tune_req  (tune_req),
        .tune_fre  (tune_fre),
        .scan_start(scan_start),
        .scan_base (scan_base),
        .scan_step (scan_step),
        .scan_count(scan_count),
        .abort     (abort),
        .iq_valid  (iq_valid),
        .I_IN      (I_IN),
        .Q_IN      (Q_IN),
        .LO_fre    (LO_fre),
        .demod_rst (demod_rst),
        .busy      (busy),
        .locked    (locked),
        .done      (done),
        .best_fre  (best_fre),
        .best_pwr  (best_pwr)
    );

    initial forever #5 clk_in = ~clk_in;

    function automatic int iq_abs(logic [11:0] v);
        int x;
        x = int'($signed(v));
        return x < 0 ? -x : x;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph = P_RETUNE;
        rl = RST_CYCLES;
        sl = 0;
        ml = 0;
        energy = 0;
        m_lo = DEF_FRE;
        m_bf = 0;
        m_bp = 0;
        m_scan = 0;
        m_done = 0;
        chans.delete();
    endtask

    task automatic model_step();
        m_done = 0;
        if (!RST_N) begin
            model_reset();
            return;
        end
        if (abort) begin
            ph = P_IDLE;
            m_scan = 0;
            chans.delete();
            return;
        end
        case (ph)
            P_IDLE, P_LOCKED: begin
                if (tune_req) begin
                    m_lo = tune_fre;
                    m_scan = 0;
                    chans.delete();
                    ph = P_RETUNE;
                    rl = RST_CYCLES;
                end else if (scan_start && scan_count != 0) begin
                    chans.delete();
                    for (int k = 1; k < int'(scan_count); k++) chans.push_back(scan_base + scan_step * 32'(k));
                    m_lo = scan_base;
                    m_scan = 1;
                    m_bf = 0;
                    m_bp = 0;
                    ph = P_RETUNE;
                    rl = RST_CYCLES;
                end
            end
            P_RETUNE: begin
                rl--;
                if (rl == 0) begin
                    ph = P_SETTLE;
                    sl = SETTLE_SAMPLES;
                end
            end
            P_SETTLE: begin
                if (iq_valid) begin
                    sl--;
                    if (sl == 0) begin
                        ph = m_scan ? P_MEASURE : P_LOCKED;
                        energy = 0;
                        ml = 1 << MEAS_LOG2;
                    end
                end
            end
            P_MEASURE: begin
                if (ml == 0) ph = P_EVAL;
                else if (iq_valid) begin
                    energy += iq_abs(I_IN) + iq_abs(Q_IN);
                    ml--;
                end
            end
            P_EVAL: begin
                if (energy > m_bp) begin
                    m_bp = energy;
                    m_bf = m_lo;
                end
                if (chans.size() > 0) m_lo = chans.pop_front();
                else begin
                    m_lo = m_bf;
                    m_scan = 0;
                    m_done = 1;
                end
                ph = P_RETUNE;
                rl = RST_CYCLES;
            end
            default: ph = P_IDLE;
        endcase
    endtask

    task automatic compare_all();
        chk("LO_fre", LO_fre, m_lo);
        chk("best_fre", best_fre, m_bf);
        chk("best_pwr", 32'(best_pwr), 32'(m_bp));
        chk("demod_rst", 32'(demod_rst), 32'(ph == P_RETUNE));
        chk("busy", 32'(busy), 32'(ph >= P_RETUNE && ph <= P_EVAL));
        chk("locked", 32'(locked), 32'(ph == P_LOCKED));
        chk("done", 32'(done), 32'(m_done));
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_step();
        @(negedge clk_in);
        compare_all();
        if (done) dones++;
    endtask

    task automatic set_iq(int vprob);
        iq_valid = $urandom_range(0, 99) < vprob;
        case (iq_mode)
            1: begin
                case (m_lo)
                    32'd1000: begin I_IN = 12'sd100;  Q_IN = -12'sd100; end
                    32'd1500: begin I_IN = 12'h800;   Q_IN = 12'sd0;    end
                    32'd2000: begin I_IN = 12'sd300;  Q_IN = 12'sd300;  end
                    default:  begin I_IN = 12'sd0;    Q_IN = 12'sd0;    end
                endcase
            end
            2: begin I_IN = 12'sd5; Q_IN = -12'sd7; end
            3: begin I_IN = (m_lo == 32'h100) ? 12'sd60 : 12'sd20; Q_IN = 12'sd0; end
            default: begin I_IN = 12'($urandom); Q_IN = 12'($urandom); end
        endcase
    endtask

    task automatic drive_cycle(int vprob);
        set_iq(vprob);
        tick();
        tune_req = 0;
        scan_start = 0;
        abort = 0;
    endtask

    task automatic wait_locked(int budget, string name);
        int n;
        n = 0;
        while (!locked && n < budget) begin
            drive_cycle(60);
            n++;
        end
        chk(name, 32'(locked), 32'd1);
    endtask

    task automatic wait_ph(int p, int budget, string name);
        int n;
        n = 0;
        while (ph != p && n < budget) begin
            drive_cycle(50);
            n++;
        end
        chk(name, 32'(ph == p), 32'd1);
    endtask

    task automatic start_scan(logic [31:0] b, logic [31:0] s, logic [7:0] c);
        scan_base = b;
        scan_step = s;
        scan_count = c;
        scan_start = 1;
        dones = 0;
        drive_cycle(50);
    endtask

    initial begin
        int r;
        RST_N = 0;
        tune_req = 0; scan_start = 0; abort = 0; iq_valid = 0;
        tune_fre = 0; scan_base = 0; scan_step = 0; scan_count = 0;
        I_IN = 0; Q_IN = 0;
        model_reset();
        tick();
        tick();
        chk("rst_lo", LO_fre, DEF_FRE);
        chk("rst_demod", 32'(demod_rst), 32'd1);
        chk("rst_busy", 32'(busy), 32'd1);
        RST_N = 1;
        // strobes during RETUNE must not count toward settling
        iq_valid = 1;
        repeat (3) tick();
        chk("rel_demod_hi", 32'(demod_rst), 32'd1);
        tick();
        chk("rel_demod_lo", 32'(demod_rst), 32'd0);
        tick();
        chk("settle_one_strobe", 32'(locked), 32'd0);
        tick();
        chk("lock_after_two", 32'(locked), 32'd1);
        chk("lock_lo", LO_fre, 32'h0010_0000);

        tune_req = 1;
        tune_fre = 32'h0100_0000;
        drive_cycle(0);
        chk("tune_lo", LO_fre, 32'h0100_0000);
        chk("tune_unlock", 32'(locked), 32'd0);
        chk("tune_busy", 32'(busy), 32'd1);
        chk("tune_demod", 32'(demod_rst), 32'd1);
        tune_req = 1;
        tune_fre = 32'h0000_DEAD;
        drive_cycle(0);
        chk("busy_ignore", LO_fre, 32'h0100_0000);
        wait_locked(100, "tune_lock_timeout");
        chk("tune_lock_lo", LO_fre, 32'h0100_0000);

        iq_mode = 1;
        start_scan(32'd1000, 32'd500, 8'd3);
        wait_locked(500, "scan_lock_timeout");
        chk("scan_done_once", 32'(dones), 32'd1);
        chk("scan_best_fre", best_fre, 32'd1500);
        chk("scan_best_pwr", 32'(best_pwr), 32'd8192);
        chk("scan_lo", LO_fre, 32'd1500);

        iq_mode = 2;
        start_scan(32'h5000, 32'h10, 8'd2);
        wait_locked(500, "tie_lock_timeout");
        chk("tie_best_fre", best_fre, 32'h5000);
        chk("tie_best_pwr", 32'(best_pwr), 32'd48);

        iq_mode = 0;
        start_scan(32'd7, 32'd1, 8'd2);
        wait_ph(P_MEASURE, 100, "abort_reach_measure");
        abort = 1;
        drive_cycle(50);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_locked", 32'(locked), 32'd0);
        chk("abort_demod", 32'(demod_rst), 32'd0);
        chk("abort_lo", LO_fre, 32'd7);
        repeat (6) drive_cycle(50);
        chk("abort_no_done", 32'(dones), 32'd0);
        chk("abort_stays_idle", 32'(busy), 32'd0);

        tune_req = 1;
        tune_fre = 32'h2222;
        start_scan(32'h3333, 32'h1, 8'd3);
        chk("both_req_lo", LO_fre, 32'h2222);
        wait_locked(100, "both_req_lock_timeout");
        chk("both_req_no_done", 32'(dones), 32'd0);
        chk("both_req_final_lo", LO_fre, 32'h2222);

        iq_mode = 3;
        start_scan(32'hFFFF_FF00, 32'h200, 8'd2);
        wait_locked(500, "wrap_lock_timeout");
        chk("wrap_best_fre", best_fre, 32'h0000_0100);
        chk("wrap_best_pwr", 32'(best_pwr), 32'd240);

        iq_mode = 0;
        tune_req = 1;
        tune_fre = 32'h4444;
        drive_cycle(0);
        wait_ph(P_SETTLE, 50, "reach_settle");
        #2;
        RST_N = 0;
        #1;
        chk("async_lo", LO_fre, DEF_FRE);
        chk("async_demod", 32'(demod_rst), 32'd1);
        chk("async_busy", 32'(busy), 32'd1);
        chk("async_locked", 32'(locked), 32'd0);
        chk("async_best_fre", best_fre, 32'd0);
        chk("async_best_pwr", 32'(best_pwr), 32'd0);
        model_reset();
        tick();
        RST_N = 1;
        wait_locked(100, "post_rst_lock_timeout");
        chk("post_rst_lo", LO_fre, DEF_FRE);

        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                tune_req = 1;
                tune_fre = $urandom;
            end
            if (r >= 2 && r < 6) begin
                scan_start = 1;
                scan_base = $urandom;
                scan_step = $urandom;
                scan_count = 8'($urandom_range(0, 3));
            end
            if (r == 99) abort = 1;
            drive_cycle(50);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/iq_tune_scheduler.md
Name: iq_tune_scheduler

Overview:
Sequencing controller for the IQ demodulator. It drives the demodulator's LO frequency word and its active-high reset, and waits out filter settling by counting decimated output samples. It supports single-channel tuning and a multi-channel scan. The scan measures |I|+|Q| energy per channel and finishes locked on the strongest channel. It sits between the control/UI logic and the demodulator; its I/Q inputs are the demodulator outputs, qualified by a one-cycle strobe in the clk_in domain.

Parameters:
IQ_WIDTH, 12, signed width of I_IN/Q_IN
CH_WIDTH, 8, width of scan_count
RST_CYCLES, 16, clk_in cycles demod_rst is held per retune (>=1)
SETTLE_SAMPLES, 8, iq_valid strobes discarded after each retune (>=1)
MEAS_LOG2, 6, log2 of strobes accumulated per scan channel
DEFAULT_FRE, 32'd0, LO word loaded at reset

Ports:
clk_in  in  1  single clock, rising edge
RST_N  in  1  asynchronous active-low reset
tune_req  in  1  one-cycle pulse: tune to tune_fre
tune_fre  in  32  target LO word
scan_start  in  1  one-cycle pulse: start a scan
scan_base  in  32  first channel LO word
scan_step  in  32  LO increment per channel
scan_count  in  CH_WIDTH  channels to scan
abort  in  1  return to IDLE immediately
iq_valid  in  1  strobe: I_IN/Q_IN hold a new decimated sample
I_IN  in  IQ_WIDTH  signed I sample
Q_IN  in  IQ_WIDTH  signed Q sample
LO_fre  out  32  frequency word to the demodulator
demod_rst  out  1  active-high reset to the demodulator
busy  out  1  high in RETUNE/SETTLE/MEASURE/EVAL
locked  out  1  high in LOCKED
done  out  1  one-cycle pulse on scan completion
best_fre  out  32  LO word of the strongest scanned channel
best_pwr  out  IQ_WIDTH+1+MEAS_LOG2  energy of that channel

Behaviour:
- Interface: one clock, clk_in. RST_N is asynchronous and active-low. While RST_N=0: state=RETUNE, counters=0, LO_fre=DEFAULT_FRE, demod_rst=1, busy=1, locked=0, done=0, best_fre=0, best_pwr=0. After release, the FSM completes a normal single tune to DEFAULT_FRE.
- States:
  - IDLE: busy=0, demod_rst=0.
  - RETUNE: demod_rst=1. Exactly RST_CYCLES cycles, then SETTLE.
  - SETTLE: count SETTLE_SAMPLES iq_valid strobes. Go to MEASURE if scanning, otherwise LOCKED.
  - MEASURE: accumulate 2^MEAS_LOG2 strobes, then EVAL.
  - EVAL: one cycle. If acc > best_pwr (strict), load best_pwr=acc and best_fre=LO_fre. If channels remain, LO_fre += scan_step and go to RETUNE. Otherwise LO_fre=best_fre, clear the scan flag, pulse done, go to RETUNE.
  - LOCKED: locked=1.
- Request acceptance: requests are accepted only in IDLE or LOCKED and ignored when busy.
  - tune_req and scan_start in the same cycle: tune_req wins.
  - scan_start with scan_count=0 is ignored.
- Accept latency: a request sampled in cycle t gives LO_fre updated, demod_rst=1, locked=0, busy=1 at t+1. demod_rst falls at t+RST_CYCLES+1.
- Scan start clears best_pwr and best_fre at acceptance; the scan flag holds the remaining-channel count.
- iq_valid is ignored in IDLE, RETUNE, EVAL and LOCKED.
- Energy metric: |I|+|Q|, unsigned, IQ_WIDTH+1 bits; |-2048| = 2048 is exact. The accumulator is IQ_WIDTH+1+MEAS_LOG2 bits, cannot overflow, and clears on MEASURE entry.
- LO arithmetic is modulo 2^32 (natural wrap).
- abort has priority over everything except reset. Next cycle: IDLE, demod_rst=0, locked=0, busy=0, no done pulse. LO_fre, best_fre and best_pwr keep their values.
- Outputs are registered, with no combinational path from input to output.

Decomposition:
- Package iq_tune_pkg: state encoding (IDLE, RETUNE, SETTLE, MEASURE, EVAL, LOCKED), and width constants for the metric and accumulator.
- Sub-module iq_power_acc: abs-sum accumulator.
  - Inputs: clear, en, I/Q.
  - Outputs: acc, and a full flag after 2^MEAS_LOG2 samples.
- The FSM, counters and LO/best registers stay in iq_tune_scheduler.

Test Plan:
(bench parameters: RST_CYCLES=4, SETTLE_SAMPLES=2, MEAS_LOG2=2, DEFAULT_FRE=32'h0010_0000)
- Reset release -> LO_fre=0x00100000; demod_rst high 4 cycles post-release; locked=1 the cycle after the 2nd iq_valid; strobes during RETUNE are not counted.
- In LOCKED, tune_req with tune_fre=0x01000000 -> next cycle LO_fre=0x01000000, locked=0, busy=1, demod_rst=1 for 4 cycles; locked after 2 further strobes. A tune_req during busy has no effect.
- Scan base=1000, step=500, count=3; channel samples are I=100,Q=-100 (metric 800), I=-2048,Q=0 (8192), I=300,Q=300 (2400) -> done pulses once, best_fre=1500, best_pwr=8192, then retune to 1500 and locked=1.
- Tie: count=2 with equal energy on both channels -> best_fre=scan_base (earliest wins).
- Wrap: base=0xFFFFFF00, step=0x200, count=2 -> second channel LO_fre=0x00000100.
- abort during MEASURE -> IDLE next cycle, busy=0, locked=0, demod_rst=0, no done. Then tune_req and scan_start in the same cycle -> a single tune occurs. RST_N pulsed mid-SETTLE -> asynchronous reset values without a clock edge.
